// File: rtl/typing_checker_if.sv
// -----------------------------------------------------------------------------
// typing_checker_if
// Bundles the keyboard/parser/score signals of the typing checker.
//   key_data, key_valid        : qualified PS/2 scan-code byte and its strobe
//   comparison_data, num_char  : current expected code and word length (parser)
//   get_next_character         : pulse, shift parser to next character
//   enable_next_level          : pulse, start game / load next word
//   char_index, level          : progress within the word / words completed
//   error_count, mistake       : saturating error total / pulse per wrong key
//   finished                   : level-high once every word is done
// modport slave  : the typing_checker side
// modport master : the environment (PS/2 receiver, parser, score logic)
// -----------------------------------------------------------------------------
interface typing_checker_if #(
  parameter int ERR_W = 16
);
  logic [7:0]       key_data;
  logic             key_valid;
  logic [7:0]       comparison_data;
  logic [7:0]       num_char;
  logic             get_next_character;
  logic             enable_next_level;
  logic [7:0]       char_index;
  logic [4:0]       level;
  logic [ERR_W-1:0] error_count;
  logic             mistake;
  logic             finished;

  modport slave (
    input  key_data, key_valid, comparison_data, num_char,
    output get_next_character, enable_next_level, char_index, level,
           error_count, mistake, finished
  );

  modport master (
    output key_data, key_valid, comparison_data, num_char,
    input  get_next_character, enable_next_level, char_index, level,
           error_count, mistake, finished
  );
endinterface

// File: rtl/typing_checker.sv
// -----------------------------------------------------------------------------
// typing_checker
// Game-control stage in front of the keyboard parser. Filters PS/2 prefix
// bytes (F0 break, E0 extended), compares qualified make codes against the
// parser's expected character and sequences words/levels.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : typing_checker_if.slave (key input, parser handshake, score outputs)
// Optional feature macro: ESC_SKIP_EN -- Esc (8'h76) while waiting for a key
// skips the rest of the word, charging the remaining characters as errors.
// All outputs are registered.
// -----------------------------------------------------------------------------
module typing_checker #(
  parameter int         NUM_LEVELS    = 30,
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] START_CODE    = 8'h5A,
  parameter int         ERR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  typing_checker_if.slave   bus
);

  localparam logic [7:0]       BRK_CODE    = 8'hF0;
  localparam logic [7:0]       EXT_CODE    = 8'hE0;
  localparam logic [4:0]       LAST_LEVEL  = 5'(NUM_LEVELS);
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
`ifdef ESC_SKIP_EN
  localparam logic [7:0]       ESC_CODE    = 8'h76;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_KEY  = 3'd2,
    S_SHIFT     = 3'd3,
    S_WORD_DONE = 3'd4,
    S_FINISHED  = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_brk, w_brk_nxt;
  logic             r_ext, w_ext_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic [7:0]       r_char_index, w_char_index_nxt;
  logic [4:0]       r_level, w_level_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic             r_gn, w_gn_nxt;
  logic             r_en, w_en_nxt;
  logic             r_mis, w_mis_nxt;
  logic             r_fin, w_fin_nxt;
  logic             w_is_prefix;
  logic             w_key_stb;

  // Saturating add of a byte-sized amount onto the error counter.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [7:0] b);
    logic [ERR_W:0] sum;
    sum = {1'b0, a} + (ERR_W+1)'(b);
    if (sum[ERR_W]) begin
      return ERR_MAX;
    end else begin
      return sum[ERR_W-1:0];
    end
  endfunction

  assign w_is_prefix = bus.key_valid &&
                       ((bus.key_data == BRK_CODE) || (bus.key_data == EXT_CODE));
  // A byte is a keystroke only when no prefix preceded it.
  assign w_key_stb   = bus.key_valid && !w_is_prefix && !r_brk && !r_ext;

  // Prefix filter: remember F0/E0 until the next non-prefix byte consumes them.
  always_comb begin
    w_brk_nxt = r_brk;
    w_ext_nxt = r_ext;
    if (bus.key_valid) begin
      if (bus.key_data == BRK_CODE) begin
        w_brk_nxt = 1'b1;
      end else if (bus.key_data == EXT_CODE) begin
        w_ext_nxt = 1'b1;
      end else begin
        w_brk_nxt = 1'b0;
        w_ext_nxt = 1'b0;
      end
    end else begin
      w_brk_nxt = r_brk;
      w_ext_nxt = r_ext;
    end
  end

  // Game FSM next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_char_index_nxt = r_char_index;
    w_level_nxt      = r_level;
    w_err_nxt        = r_err;
    w_gn_nxt         = 1'b0;
    w_en_nxt         = 1'b0;
    w_mis_nxt        = 1'b0;
    w_fin_nxt        = r_fin;
    case (r_state)
      S_IDLE: begin
        if (w_key_stb && (bus.key_data == START_CODE)) begin
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = SETTLE_LOAD;
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      // Parser load pipeline settles; keystrokes here are discarded.
      S_LOAD: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_WAIT_KEY;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_WAIT_KEY: begin
        if (w_key_stb) begin
`ifdef ESC_SKIP_EN
          if (bus.key_data == ESC_CODE) begin
            w_err_nxt   = sat_add(r_err, bus.num_char - r_char_index);
            w_mis_nxt   = 1'b1;
            w_state_nxt = S_WORD_DONE;
          end else
`endif
          if (bus.key_data == bus.comparison_data) begin
            w_gn_nxt         = 1'b1;
            w_char_index_nxt = r_char_index + 8'd1;
            w_state_nxt      = S_SHIFT;
          end else begin
            w_mis_nxt = 1'b1;
            w_err_nxt = sat_add(r_err, 8'd1);
          end
        end else begin
          w_state_nxt = S_WAIT_KEY;
        end
      end
      // One cycle for the parser's shift register; empty words cannot hang.
      S_SHIFT: begin
        if ((r_char_index == bus.num_char) || (bus.num_char == 8'd0)) begin
          w_state_nxt = S_WORD_DONE;
        end else begin
          w_state_nxt = S_WAIT_KEY;
        end
      end
      S_WORD_DONE: begin
        w_level_nxt      = r_level + 5'd1;
        w_char_index_nxt = 8'd0;
        if ((r_level + 5'd1) == LAST_LEVEL) begin
          w_fin_nxt   = 1'b1;
          w_state_nxt = S_FINISHED;
        end else begin
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = SETTLE_LOAD;
          w_state_nxt = S_LOAD;
        end
      end
      S_FINISHED: begin
        w_fin_nxt   = 1'b1;
        w_state_nxt = S_FINISHED;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, prefix flags and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_cnt        <= 8'd0;
      r_char_index <= 8'd0;
      r_level      <= 5'd0;
      r_err        <= {ERR_W{1'b0}};
      r_gn         <= 1'b0;
      r_en         <= 1'b0;
      r_mis        <= 1'b0;
      r_fin        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_brk        <= w_brk_nxt;
      r_ext        <= w_ext_nxt;
      r_cnt        <= w_cnt_nxt;
      r_char_index <= w_char_index_nxt;
      r_level      <= w_level_nxt;
      r_err        <= w_err_nxt;
      r_gn         <= w_gn_nxt;
      r_en         <= w_en_nxt;
      r_mis        <= w_mis_nxt;
      r_fin        <= w_fin_nxt;
    end
  end

  assign bus.get_next_character = r_gn;
  assign bus.enable_next_level  = r_en;
  assign bus.char_index         = r_char_index;
  assign bus.level              = r_level;
  assign bus.error_count        = r_err;
  assign bus.mistake            = r_mis;
  assign bus.finished           = r_fin;

endmodule

// File: tb/tb_typing_checker.sv
// -----------------------------------------------------------------------------
// tb_typing_checker
// Self-checking bench for typing_checker (NUM_LEVELS = 2). A small parser stub
// supplies comparison_data / num_char from a word table; expected counters come
// from a game-level model (per keystroke, not per cycle).
// -----------------------------------------------------------------------------
module tb_typing_checker;
  localparam int NUM_LEVELS = 2;
  localparam int SETTLE     = 4;
  localparam int ERR_W      = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  typing_checker_if #(.ERR_W(ERR_W)) ifc ();

  typing_checker #(
    .NUM_LEVELS(NUM_LEVELS), .SETTLE_CYCLES(SETTLE),
    .START_CODE(8'h5A), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave)
  );

  // Parser stub: word table, loads on enable, shifts on get_next.
  logic [7:0] wchr [0:1][0:7];
  logic [7:0] wlen [0:1];
  logic [1:0] p_loads;
  logic       p_word;
  logic [2:0] p_idx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p_loads <= 2'd0; p_word <= 1'b0; p_idx <= 3'd0;
    end else if (ifc.enable_next_level) begin
      p_word <= p_loads[0]; p_loads <= p_loads + 2'd1; p_idx <= 3'd0;
    end else if (ifc.get_next_character) begin
      p_idx <= p_idx + 3'd1;
    end
  end

  assign ifc.comparison_data = wchr[p_word][p_idx];
  assign ifc.num_char        = wlen[p_word];

  // Pulse counters (one count per cycle high).
  int cnt_gn = 0, cnt_en = 0, cnt_mis = 0;
  always @(negedge clk) begin
    if (ifc.get_next_character) cnt_gn = cnt_gn + 1;
    if (ifc.enable_next_level)  cnt_en = cnt_en + 1;
    if (ifc.mistake)            cnt_mis = cnt_mis + 1;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    ifc.key_data = b; ifc.key_valid = 1'b1;
    tick();
    ifc.key_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic set_word(input int w, input logic [7:0] c0, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [7:0] len);
    wchr[w][0] = c0; wchr[w][1] = c1; wchr[w][2] = c2; wlen[w] = len;
  endtask

  task automatic test_reset();
    reset = 1'b1; ifc.key_valid = 1'b0; ifc.key_data = 8'h00;
    set_word(0, 8'h24, 8'h21, 8'h2B, 8'd3);
    set_word(1, 8'h24, 8'h2D, 8'h2C, 8'd3);
    idle(2);
    n_checks++;
    if ({ifc.get_next_character, ifc.enable_next_level, ifc.char_index, ifc.level,
         ifc.error_count, ifc.mistake, ifc.finished} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: gn=%0b en=%0b idx=%0d lvl=%0d err=%0d mis=%0b fin=%0b, want all 0",
               ifc.get_next_character, ifc.enable_next_level, ifc.char_index, ifc.level,
               ifc.error_count, ifc.mistake, ifc.finished);
    end
    reset = 1'b0; tick();
  endtask

  task automatic test_first_word();
    int b_gn, b_en;
    b_gn = cnt_gn; b_en = cnt_en;
    send_byte(8'h5A);
    n_checks++;
    if (ifc.enable_next_level !== 1'b1) begin
      n_fail++; $display("FAIL start_pulse: enable=%0b want 1", ifc.enable_next_level);
    end
    idle(3);
    send_byte(8'h24);                      // last settle cycle: dropped
    n_checks++;
    if (ifc.get_next_character !== 1'b0 || ifc.error_count !== 16'd0) begin
      n_fail++; $display("FAIL load_drop: gn=%0b err=%0d want 0/0", ifc.get_next_character, ifc.error_count);
    end
    send_byte(8'h24);                      // first cycle in wait state
    n_checks++;
    if (ifc.get_next_character !== 1'b1 || ifc.char_index !== 8'd1) begin
      n_fail++; $display("FAIL first_key: gn=%0b idx=%0d want 1/1", ifc.get_next_character, ifc.char_index);
    end
    tick(); send_byte(8'h21); tick(); send_byte(8'h2B);
    n_checks++;
    if (ifc.char_index !== 8'd3) begin
      n_fail++; $display("FAIL idx_three: idx=%0d want 3", ifc.char_index);
    end
    idle(3);
    n_checks++;
    if (ifc.level !== 5'd1 || ifc.char_index !== 8'd0) begin
      n_fail++; $display("FAIL word_done: lvl=%0d idx=%0d want 1/0", ifc.level, ifc.char_index);
    end
    n_checks++;
    if ((cnt_gn - b_gn) !== 3 || (cnt_en - b_en) !== 2) begin
      n_fail++; $display("FAIL word_pulses: gn=%0d en=%0d want 3/2", cnt_gn - b_gn, cnt_en - b_en);
    end
    idle(3);
  endtask

  task automatic test_prefix_and_finish();
    int b_gn, b_en;
    b_gn = cnt_gn; b_en = cnt_en;
    send_byte(8'hF0); send_byte(8'h24); tick();
    n_checks++;
    if (cnt_gn !== b_gn || ifc.error_count !== 16'd0 || ifc.char_index !== 8'd0) begin
      n_fail++; $display("FAIL break_drop: gn=%0d err=%0d idx=%0d want %0d/0/0", cnt_gn, ifc.error_count, ifc.char_index, b_gn);
    end
    send_byte(8'h24);
    n_checks++;
    if (ifc.get_next_character !== 1'b1) begin
      n_fail++; $display("FAIL after_break: gn=%0b want 1", ifc.get_next_character);
    end
    tick();
    send_byte(8'h1C);
    n_checks++;
    if (ifc.mistake !== 1'b1 || ifc.error_count !== 16'd1 || ifc.char_index !== 8'd1) begin
      n_fail++; $display("FAIL wrong_key: mis=%0b err=%0d idx=%0d want 1/1/1", ifc.mistake, ifc.error_count, ifc.char_index);
    end
    send_byte(8'hE0); send_byte(8'h2D); tick();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h2D); tick();
    n_checks++;
    if (ifc.error_count !== 16'd1 || ifc.char_index !== 8'd1 || cnt_gn !== b_gn + 1) begin
      n_fail++; $display("FAIL ext_drop: err=%0d idx=%0d gn=%0d want 1/1/%0d", ifc.error_count, ifc.char_index, cnt_gn, b_gn + 1);
    end
    send_byte(8'h2D); tick(); send_byte(8'h2C); idle(4);
    n_checks++;
    if (ifc.finished !== 1'b1 || ifc.level !== 5'd2 || ifc.char_index !== 8'd0 || cnt_en !== b_en) begin
      n_fail++; $display("FAIL finish: fin=%0b lvl=%0d idx=%0d en=%0d want 1/2/0/%0d", ifc.finished, ifc.level, ifc.char_index, cnt_en, b_en);
    end
    send_byte(8'h5A); idle(6); send_byte(8'h1C); idle(2);
    n_checks++;
    if (ifc.finished !== 1'b1 || cnt_en !== b_en || ifc.error_count !== 16'd1 || cnt_gn !== b_gn + 3) begin
      n_fail++; $display("FAIL finished_ignores: fin=%0b en=%0d err=%0d gn=%0d", ifc.finished, cnt_en, ifc.error_count, cnt_gn);
    end
  endtask

  task automatic test_saturation_and_async_reset();
    int b_mis;
    pulse_reset();
    set_word(0, 8'h24, 8'h21, 8'h2B, 8'd3);
    send_byte(8'h5A); idle(4);
    b_mis = cnt_mis;
    ifc.key_data = 8'h1C; ifc.key_valid = 1'b1;
    repeat (65537) tick();
    ifc.key_valid = 1'b0; idle(2);
    n_checks++;
    if (ifc.error_count !== 16'hFFFF || (cnt_mis - b_mis) !== 65537) begin
      n_fail++; $display("FAIL saturate: err=%0h mis=%0d want ffff/65537", ifc.error_count, cnt_mis - b_mis);
    end
    send_byte(8'h24); idle(2);
    n_checks++;
    if (ifc.char_index !== 8'd1) begin
      n_fail++; $display("FAIL pre_reset_idx: idx=%0d want 1", ifc.char_index);
    end
    #2 reset = 1'b1; #1;                   // between clock edges
    n_checks++;
    if ({ifc.get_next_character, ifc.enable_next_level, ifc.char_index, ifc.level,
         ifc.error_count, ifc.mistake, ifc.finished} !== 39'd0) begin
      n_fail++; $display("FAIL async_reset: idx=%0d lvl=%0d err=%0d fin=%0b want 0",
                         ifc.char_index, ifc.level, ifc.error_count, ifc.finished);
    end
    tick(); reset = 1'b0; tick();
  endtask

  task automatic test_random_games();
    int m_idx, m_lvl, m_err, m_gn, m_en, m_mis, steps, op;
    bit m_fin;
    logic [7:0] b, exp_c;
    for (int g = 0; g < 5; g++) begin
      for (int w = 0; w < 2; w++) begin
        wlen[w] = 8'($urandom_range(1, 5));
        for (int c = 0; c < 8; c++) begin
          do b = 8'($urandom_range(1, 255));
          while (b == 8'hF0 || b == 8'hE0 || b == 8'h76);
          wchr[w][c] = b;
        end
      end
      pulse_reset();
      m_idx = 0; m_lvl = 0; m_err = 0; m_fin = 1'b0;
      m_gn = cnt_gn; m_en = cnt_en + 1; m_mis = cnt_mis;
      send_byte(8'h5A); idle(5);
      steps = 0;
      while (!m_fin && steps < 300) begin
        steps++;
        exp_c = wchr[m_lvl][m_idx];
        op = $urandom_range(0, 4);
        case (op)
          0: begin
            send_byte(exp_c);
            m_gn++; m_idx++;
            if (m_idx == int'(wlen[m_lvl])) begin
              m_idx = 0; m_lvl++;
              if (m_lvl == NUM_LEVELS) m_fin = 1'b1;
              else m_en++;
            end
          end
          1: begin
            do b = 8'($urandom_range(0, 255));
            while (b == exp_c || b == 8'hF0 || b == 8'hE0 || b == 8'h76);
            send_byte(b);
            m_mis++;
            if (m_err < 65535) m_err++;
          end
          2: begin send_byte(8'hF0); send_byte(exp_c); end
          3: begin send_byte(8'hE0); send_byte(exp_c); end
          default: begin send_byte(8'hE0); send_byte(8'hF0); send_byte(exp_c); end
        endcase
        idle(8);
        n_checks++;
        if (ifc.char_index !== 8'(m_idx) || ifc.level !== 5'(m_lvl) || ifc.finished !== m_fin) begin
          n_fail++; $display("FAIL rand_progress g%0d op%0d: idx=%0d lvl=%0d fin=%0b want %0d/%0d/%0b",
                             g, op, ifc.char_index, ifc.level, ifc.finished, m_idx, m_lvl, m_fin);
        end
        n_checks++;
        if (ifc.error_count !== 16'(m_err)) begin
          n_fail++; $display("FAIL rand_err g%0d: err=%0d want %0d", g, ifc.error_count, m_err);
        end
        n_checks++;
        if (cnt_gn !== m_gn || cnt_en !== m_en || cnt_mis !== m_mis) begin
          n_fail++; $display("FAIL rand_pulses g%0d: gn=%0d en=%0d mis=%0d want %0d/%0d/%0d",
                             g, cnt_gn, cnt_en, cnt_mis, m_gn, m_en, m_mis);
        end
      end
      n_checks++;
      if (!m_fin) begin
        n_fail++; $display("FAIL rand_budget g%0d: game not finished within step budget", g);
      end
    end
  endtask

`ifdef ESC_SKIP_EN
  task automatic test_esc_skip();
    int b_en;
    pulse_reset();
    set_word(0, 8'h24, 8'h21, 8'h2B, 8'd3);
    set_word(1, 8'h24, 8'h2D, 8'h2C, 8'd3);
    b_en = cnt_en;
    send_byte(8'h5A); idle(4);
    send_byte(8'h24); tick();
    send_byte(8'h76);
    n_checks++;
    if (ifc.mistake !== 1'b1) begin
      n_fail++; $display("FAIL esc_mistake: mis=%0b want 1", ifc.mistake);
    end
    idle(6);
    n_checks++;
    if (ifc.error_count !== 16'd2 || ifc.level !== 5'd1 || ifc.char_index !== 8'd0 || (cnt_en - b_en) !== 2) begin
      n_fail++; $display("FAIL esc_skip: err=%0d lvl=%0d idx=%0d en=%0d want 2/1/0/2",
                         ifc.error_count, ifc.level, ifc.char_index, cnt_en - b_en);
    end
  endtask
`endif

  initial begin
    ifc.key_valid = 1'b0;
    ifc.key_data  = 8'h00;
    test_reset();
    test_first_word();
    test_prefix_and_finish();
    test_saturation_and_async_reset();
    test_random_games();
`ifdef ESC_SKIP_EN
    test_esc_skip();
`endif
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
